// File: rtl/pkt_out_framer.sv
// Egress-port framer: SOF byte, port address, then FIFO payload up to and including the delimiter.
// Optional build macro PKT_OUT_LEN_GUARD_EN adds MAX_LEN runaway-packet truncation (len_cnt, FLUSH, trunc_err).
module pkt_out_framer #(
   parameter int                 W_WIDTH   = 8,
   parameter logic [W_WIDTH-1:0] SOF_BYTE  = {W_WIDTH{1'b1}},
   parameter logic [W_WIDTH-1:0] DELIMITER = {W_WIDTH{1'b0}},
   parameter int                 MAX_LEN   = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               port_rd,
   input  logic [W_WIDTH-1:0] port_addr,
   input  logic               port_empty,
   input  logic [W_WIDTH-1:0] fifo_data,
   output logic               rd_en,
   output logic [W_WIDTH-1:0] port_out,
   output logic               port_out_vld,
   output logic               busy,
   output logic               trunc_err
);

   if (MAX_LEN < 2) begin : g_bad_max_len
      $error("pkt_out_framer: MAX_LEN must be at least 2");
   end

`ifdef PKT_OUT_LEN_GUARD_EN
   typedef enum logic [2:0] {IDLE, SOF, ADDR, PAYLOAD, FLUSH} state_t;
`else
   typedef enum logic [1:0] {IDLE, SOF, ADDR, PAYLOAD} state_t;
`endif

   state_t             state;
   logic [W_WIDTH-1:0] addr_q;
   logic               fifo_vld_q;
   logic               is_delim;

   // A delimiter sitting on fifo_data ends the packet, so the pop that would fetch the next packet is withheld.
   assign is_delim = fifo_vld_q && (fifo_data == DELIMITER);
   assign rd_en    = (state != IDLE) && !port_empty && !is_delim;
   assign busy     = (state != IDLE);

`ifdef PKT_OUT_LEN_GUARD_EN
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic [LEN_W-1:0] len_cnt;
   logic             at_limit;

   assign at_limit = (len_cnt == LEN_W'(MAX_LEN - 1));
`else
   assign trunc_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         addr_q       <= '0;
         fifo_vld_q   <= 1'b0;
         port_out     <= '0;
         port_out_vld <= 1'b0;
`ifdef PKT_OUT_LEN_GUARD_EN
         len_cnt      <= '0;
         trunc_err    <= 1'b0;
`endif
      end else begin
         fifo_vld_q <= rd_en;
`ifdef PKT_OUT_LEN_GUARD_EN
         trunc_err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               port_out_vld <= 1'b0;
               if (port_rd && !port_empty) begin
                  addr_q       <= port_addr;
                  port_out     <= SOF_BYTE;
                  port_out_vld <= 1'b1;
                  state        <= SOF;
`ifdef PKT_OUT_LEN_GUARD_EN
                  len_cnt      <= '0;
`endif
               end
            end
            SOF: begin
               port_out     <= addr_q;
               port_out_vld <= 1'b1;
               state        <= ADDR;
            end
            // The word popped in SOF lands while the address is on the port, so ADDR already forwards payload.
            ADDR, PAYLOAD: begin
               state        <= PAYLOAD;
               port_out_vld <= fifo_vld_q;
               if (fifo_vld_q) begin
`ifdef PKT_OUT_LEN_GUARD_EN
                  if (at_limit && !is_delim) begin
                     port_out  <= DELIMITER;
                     trunc_err <= 1'b1;
                     state     <= FLUSH;
                  end else begin
                     port_out <= fifo_data;
                     len_cnt  <= len_cnt + LEN_W'(1);
                     if (is_delim) state <= IDLE;
                  end
`else
                  port_out <= fifo_data;
                  if (is_delim) state <= IDLE;
`endif
               end
            end
`ifdef PKT_OUT_LEN_GUARD_EN
            FLUSH: begin
               port_out_vld <= 1'b0;
               if (is_delim) state <= IDLE;
            end
`endif
            default: begin
               port_out_vld <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_out_framer.sv
// Directed bench for pkt_out_framer with a behavioural egress FIFO (one-cycle read latency, scripted underrun gaps).
module tb_pkt_out_framer;
   localparam int W  = 8;
   localparam int ML = 4;

   logic         clk        = 1'b0;
   logic         rst_n      = 1'b0;
   logic         port_rd    = 1'b0;
   logic [W-1:0] port_addr  = '0;
   logic         port_empty;
   logic [W-1:0] fifo_data  = '0;
   logic         rd_en;
   logic [W-1:0] port_out;
   logic         port_out_vld;
   logic         busy;
   logic         trunc_err;

   logic [W-1:0] mem [0:255];
   int           rd_ptr = 0;
   int           wr_ptr = 0;
   int           stall = 0;
   int           gap_at = -1;
   int           empty_viol = 0;
   logic         hold_empty = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign port_empty = (rd_ptr == wr_ptr) || (stall != 0) || hold_empty;

   pkt_out_framer #(
      .W_WIDTH  (W),
      .SOF_BYTE (8'hFF),
      .DELIMITER(8'h00),
      .MAX_LEN  (ML)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .port_rd     (port_rd),
      .port_addr   (port_addr),
      .port_empty  (port_empty),
      .fifo_data   (fifo_data),
      .rd_en       (rd_en),
      .port_out    (port_out),
      .port_out_vld(port_out_vld),
      .busy        (busy),
      .trunc_err   (trunc_err)
   );

   // FIFO model: read data appears the cycle after a pop; popping word gap_at opens a 3-cycle empty window.
   always @(posedge clk) begin
      if (stall != 0) begin
         stall <= stall - 1;
      end else if (rd_en && !port_empty) begin
         fifo_data <= mem[rd_ptr[7:0]];
         rd_ptr    <= rd_ptr + 1;
         if (rd_ptr == gap_at) stall <= 3;
      end
   end

   always @(negedge clk) begin
      if (rd_en && port_empty) empty_viol <= empty_viol + 1;
   end

   task automatic push(input logic [W-1:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++;
      if (port_out !== 8'h00 || port_out_vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_out: got out=%h vld=%b, want out=00 vld=0", port_out, port_out_vld);
      end
      total++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || trunc_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl: got busy=%b rd_en=%b trunc=%b, want 0 0 0", busy, rd_en, trunc_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [W-1:0] exp [0:4];
      int start;
      exp   = '{8'hFF, 8'h05, 8'h11, 8'h22, 8'h00};
      start = rd_ptr;
      push(8'h11); push(8'h22); push(8'h00);
      port_addr = 8'h05;
      port_rd   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         port_rd = 1'b0;
         total++;
         if (port_out_vld !== 1'b1 || port_out !== exp[i]) begin
            bad++;
            $display("FAIL basic[%0d]: got vld=%b out=%h, want vld=1 out=%h", i, port_out_vld, port_out, exp[i]);
         end
      end
      @(negedge clk);
      total++;
      if (port_out_vld !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_end: got vld=%b busy=%b, want 0 0", port_out_vld, busy);
      end
      total++;
      if (rd_ptr - start !== 3) begin
         bad++;
         $display("FAIL basic_pops: got %0d pops, want 3", rd_ptr - start);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] exp [0:7];
      int start;
      exp   = '{8'hFF, 8'h3C, 8'hA1, 8'h00, 8'hFF, 8'h3C, 8'hB2, 8'h00};
      start = rd_ptr;
      push(8'hA1); push(8'h00); push(8'hB2); push(8'h00);
      port_addr = 8'h3C;
      port_rd   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if (port_out_vld !== 1'b1 || port_out !== exp[i]) begin
            bad++;
            $display("FAIL b2b[%0d]: got vld=%b out=%h, want vld=1 out=%h", i, port_out_vld, port_out, exp[i]);
         end
         if (i == 3) begin
            total++;
            if (rd_ptr - start !== 2) begin
               bad++;
               $display("FAIL b2b_overread: got %0d pops at delimiter, want 2", rd_ptr - start);
            end
         end
         if (i == 4) port_rd = 1'b0;
      end
      @(negedge clk);
      total++;
      if (port_out_vld !== 1'b0 || rd_ptr - start !== 4) begin
         bad++;
         $display("FAIL b2b_end: got vld=%b pops=%0d, want vld=0 pops=4", port_out_vld, rd_ptr - start);
      end
   endtask

   task automatic test_underrun;
      logic [W-1:0] exp_d [0:7];
      logic         exp_v [0:7];
      exp_d  = '{8'hFF, 8'h42, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h00};
      exp_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      gap_at = wr_ptr;
      push(8'h11); push(8'h22); push(8'h00);
      port_addr = 8'h42;
      port_rd   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         port_rd = 1'b0;
         total++;
         if (port_out_vld !== exp_v[i] || port_out !== exp_d[i]) begin
            bad++;
            $display("FAIL underrun[%0d]: got vld=%b out=%h, want vld=%b out=%h",
                     i, port_out_vld, port_out, exp_v[i], exp_d[i]);
         end
      end
      gap_at = -1;
      @(negedge clk);
      total++;
      if (port_out_vld !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL underrun_end: got vld=%b busy=%b, want 0 0", port_out_vld, busy);
      end
   endtask

   task automatic test_truncation;
      logic [W-1:0] exp_d [0:8];
      logic         exp_v [0:8];
      logic         exp_t [0:8];
      logic [W-1:0] nxt [0:3];
      int start;
`ifdef PKT_OUT_LEN_GUARD_EN
      exp_d = '{8'hFF, 8'h77, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
      exp_d = '{8'hFF, 8'h77, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00};
      exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      nxt   = '{8'hFF, 8'h10, 8'hAB, 8'h00};
      start = rd_ptr;
      push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05); push(8'h00);
      port_addr = 8'h77;
      port_rd   = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         port_rd = 1'b0;
         total++;
         if (port_out_vld !== exp_v[i] || port_out !== exp_d[i] || trunc_err !== exp_t[i]) begin
            bad++;
            $display("FAIL trunc[%0d]: got vld=%b out=%h trunc=%b, want vld=%b out=%h trunc=%b",
                     i, port_out_vld, port_out, trunc_err, exp_v[i], exp_d[i], exp_t[i]);
         end
      end
      total++;
      if (busy !== 1'b0 || rd_ptr - start !== 6) begin
         bad++;
         $display("FAIL trunc_drain: got busy=%b pops=%0d, want busy=0 pops=6", busy, rd_ptr - start);
      end
      push(8'hAB); push(8'h00);
      port_addr = 8'h10;
      port_rd   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         port_rd = 1'b0;
         total++;
         if (port_out_vld !== 1'b1 || port_out !== nxt[i]) begin
            bad++;
            $display("FAIL trunc_next[%0d]: got vld=%b out=%h, want vld=1 out=%h", i, port_out_vld, port_out, nxt[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_packet;
      logic [W-1:0] exp [0:3];
      logic [W-1:0] aft [0:3];
      int start;
      exp   = '{8'hFF, 8'h55, 8'h31, 8'h32};
      aft   = '{8'hFF, 8'h66, 8'h34, 8'h00};
      start = rd_ptr;
      push(8'h31); push(8'h32); push(8'h33); push(8'h34); push(8'h00);
      port_addr = 8'h55;
      port_rd   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         port_rd = 1'b0;
         total++;
         if (port_out_vld !== 1'b1 || port_out !== exp[i]) begin
            bad++;
            $display("FAIL rst_mid_pre[%0d]: got vld=%b out=%h, want vld=1 out=%h", i, port_out_vld, port_out, exp[i]);
         end
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (port_out !== 8'h00 || port_out_vld !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || trunc_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_async: got out=%h vld=%b busy=%b rd_en=%b trunc=%b, want all 0",
                  port_out, port_out_vld, busy, rd_en, trunc_err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || rd_ptr - start !== 3) begin
         bad++;
         $display("FAIL rst_mid_idle: got busy=%b pops=%0d, want busy=0 pops=3", busy, rd_ptr - start);
      end
      port_addr = 8'h66;
      port_rd   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         port_rd = 1'b0;
         total++;
         if (port_out_vld !== 1'b1 || port_out !== aft[i]) begin
            bad++;
            $display("FAIL rst_mid_post[%0d]: got vld=%b out=%h, want vld=1 out=%h", i, port_out_vld, port_out, aft[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_idle_hold;
      logic [W-1:0] exp [0:3];
      exp = '{8'hFF, 8'h21, 8'h99, 8'h00};
      push(8'h99); push(8'h00);
      port_addr = 8'h21;
      port_rd   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if ({rd_en, port_out_vld, busy} !== 3'b000) begin
            bad++;
            $display("FAIL idle_no_rd[%0d]: got rd_en=%b vld=%b busy=%b, want 0 0 0", i, rd_en, port_out_vld, busy);
         end
      end
      hold_empty = 1'b1;
      port_rd    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if ({rd_en, port_out_vld, busy} !== 3'b000) begin
            bad++;
            $display("FAIL idle_empty[%0d]: got rd_en=%b vld=%b busy=%b, want 0 0 0", i, rd_en, port_out_vld, busy);
         end
      end
      hold_empty = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         port_rd = 1'b0;
         total++;
         if (port_out_vld !== 1'b1 || port_out !== exp[i]) begin
            bad++;
            $display("FAIL idle_release[%0d]: got vld=%b out=%h, want vld=1 out=%h", i, port_out_vld, port_out, exp[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_rd_guard;
      total++;
      if (empty_viol !== 0) begin
         bad++;
         $display("FAIL rd_while_empty: got %0d cycles with rd_en=1 and port_empty=1, want 0", empty_viol);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_underrun();
      test_truncation();
      test_reset_mid_packet();
      test_idle_hold();
      test_rd_guard();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pkt_out_framer.md
# pkt_out_framer

Parametrised output-port framer for the simple switch. One instance per egress port. It waits for a read grant, then drives a framed packet onto the port: a start-of-frame byte, the port address, then payload bytes popped from the egress FIFO up to and including the delimiter. It adds a per-byte valid flag, stalls cleanly on FIFO underrun, avoids over-reading across packet boundaries, and guards against runaway packets with a maximum-length truncation.

## Interface
- W_WIDTH, 8: data, address and FIFO word width.
- SOF_BYTE, {W_WIDTH{1'b1}}: start-of-frame symbol.
- DELIMITER, {W_WIDTH{1'b0}}: end-of-packet symbol.
- MAX_LEN, 64: maximum payload words, delimiter included, before forced truncation; must be ≥ 2.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- port_rd  in  1  grant to start a packet; sampled only in IDLE.
- port_addr  in  W_WIDTH  egress address; captured when a packet starts.
- port_empty  in  1  egress FIFO empty.
- fifo_data  in  W_WIDTH  FIFO read data, valid the cycle after an accepted pop.
- rd_en  out  1  FIFO pop request; combinational from registered state, port_empty and fifo_data.
- port_out  out  W_WIDTH  framed output byte, registered.
- port_out_vld  out  1  port_out carries a valid byte this cycle, registered.
- busy  out  1  state != IDLE.
- trunc_err  out  1  one-cycle pulse when a packet is truncated.

## Operation
- States: IDLE, SOF, ADDR, PAYLOAD, FLUSH.
- A pop is accepted when rd_en=1 and port_empty=0. fifo_vld_q registers each accepted pop.
- rd_en is never asserted while port_empty=1 or while in IDLE.
- IDLE: if port_rd=1 and port_empty=0, capture port_addr and go to SOF. Otherwise stay.
- SOF: emit SOF_BYTE, raise rd_en, go to ADDR.
- ADDR: emit captured address, keep rd_en, go to PAYLOAD.
- PAYLOAD, when fifo_vld_q=1: forward fifo_data with valid=1 and increment len_cnt.
  - If fifo_data==DELIMITER, go to IDLE. rd_en is 0 in that same cycle, so no byte of the next packet is popped.
- PAYLOAD, when fifo_vld_q=0 (underrun): valid=0, port_out holds its value, state holds.
- Truncation: when a non-delimiter word would make len_cnt reach MAX_LEN, emit DELIMITER in its place, pulse trunc_err, and go to FLUSH.
- FLUSH: pop and discard with valid=0 until the popped word is a DELIMITER, then go to IDLE.
- port_rd deasserting mid-packet is ignored; the packet completes.
- len_cnt width is $clog2(MAX_LEN+1). It clears when a packet starts.
- Reset, asynchronous at any point including mid-packet:
  - state=IDLE, len_cnt=0, fifo_vld_q=0.
  - port_out=0, port_out_vld=0, trunc_err=0, busy=0, rd_en=0.
  - No partial frame is resumed after reset.

## Timing
- Start sampled in cycle T (IDLE).
  - T+1: port_out=SOF_BYTE, vld=1.
  - T+2: port_out=address, vld=1.
  - T+3: first payload byte, when the FIFO has not underrun.
- rd_en is high from T+1 onward while port_empty=0 and no stop condition holds.
- With no underrun, payload streams one word per cycle with no bubbles.
- Packet n delimiter appears at cycle k; the IDLE cycle that follows can start packet n+1, whose SOF appears at k+1. There is no dead cycle when port_rd=1 and the FIFO is non-empty.
- Frame latency for L payload words with no underrun: L+2 output cycles.
- Simultaneous port_rd=1 and port_empty=1: no start; re-evaluated every cycle.

## Configuration
- PKT_OUT_LEN_GUARD_EN defined:
  - len_cnt, MAX_LEN truncation, FLUSH and trunc_err are present.
- PKT_OUT_LEN_GUARD_EN undefined:
  - No counter and no FLUSH state; trunc_err is tied 0.
  - PAYLOAD runs until a delimiter arrives, regardless of length.
  - All other behaviour is identical.

## Test plan
- Basic frame: port_addr=0x05, FIFO holds 0x11,0x22,0x00, port_rd=1.
  - port_out = FF,05,11,22,00 on consecutive cycles, all vld=1.
  - rd_en pops exactly 3 words.
- Back-to-back: FIFO holds 0xA1,0x00,0xB2,0x00, port_rd held at 1.
  - FF,addr,A1,00,FF,addr,B2,00 with no gaps.
  - 0xB2 is not popped during packet 1.
- Underrun: FIFO empty for 3 cycles after 0x11.
  - vld=0 for exactly 3 cycles with port_out held at 0x11, then 0x22,0x00 resume.
- Truncation (guard enabled, MAX_LEN=4): payload 01,02,03,04,05,00.
  - Output FF,addr,01,02,03,00; trunc_err pulses once.
  - 04,05,00 are popped with vld=0; next packet starts cleanly.
- Reset mid-payload: rst_n low after the second payload byte.
  - All outputs are 0 immediately; state IDLE.
  - After release, a new grant yields FF,addr,… from the current FIFO head.
- Idle hold: port_rd=0 with a non-empty FIFO, or port_rd=1 with port_empty=1, for 10 cycles.
  - rd_en=0, vld=0, busy=0 throughout.
